dac7621_wr_ctrl: RTL

DAC7621_WR_CTRL -- requirements
Module: dac7621_wr_ctrl

---
 rtl/dac7621_wr_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dac7621_wr_ctrl.sv
// Parallel write sequencer for the DAC7621: latches one 12-bit sample, then runs
// setup / chip-select strobe / hold / LOADDAC phases, all outputs straight from flops.
module dac7621_wr_ctrl #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned LOAD_CYC   = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  output logic        sample_ready,
  output logic [11:0] dac_data,
  output logic        dac_cs_n,
  output logic        dac_rw,
  output logic        dac_load_n,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : gen_bad_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : gen_bad_strobe
    $error("STROBE_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : gen_bad_hold
    $error("HOLD_CYC must be in 1..15");
  end
  if (LOAD_CYC < 1 || LOAD_CYC > 15) begin : gen_bad_load
    $error("LOAD_CYC must be in 1..15");
  end

  // Counters are preloaded with N-1 so each phase lasts exactly N cycles.
  localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] LoadLd   = 4'(LOAD_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StLoad
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      dac_data     <= 12'h000;
      dac_cs_n     <= 1'b1;
      dac_rw       <= 1'b1;
      dac_load_n   <= 1'b1;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      drop_cnt     <= 16'h0000;
    end else begin
      if (sample_valid && !sample_ready && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          // First edge out of reset lands here with ready low, so it only arms ready.
          sample_ready <= 1'b1;
          if (sample_valid && sample_ready) begin
            dac_data     <= sample_data;
            state_q      <= StSetup;
            cnt_q        <= SetupLd;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
            dac_rw       <= 1'b0;
          end
        end
        StSetup: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StStrobe;
            cnt_q    <= StrobeLd;
            dac_cs_n <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StHold;
            cnt_q    <= HoldLd;
            dac_cs_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          if (cnt_q == 4'd0) begin
            state_q    <= StLoad;
            cnt_q      <= LoadLd;
            dac_load_n <= 1'b0;
            dac_rw     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StLoad: begin
          if (cnt_q == 4'd0) begin
            state_q      <= StIdle;
            dac_load_n   <= 1'b1;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q      <= StIdle;
          dac_cs_n     <= 1'b1;
          dac_load_n   <= 1'b1;
          dac_rw       <= 1'b1;
          sample_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
